// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO burst reader and its stream buffer.
package fifo_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned LEN_WIDTH_DEF  = 10;
  localparam logic [1:0]  SKID_DEPTH     = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry register buffer feeding a valid/ready stream; head entry drives m_data.
module stream_skid2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             m_ready,
  output logic [1:0]       occ,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] tail;
  logic             pop;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Producer never pushes into a full buffer without a simultaneous pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ    <= '0;
      m_data <= '0;
      tail   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) m_data <= push_data;
          else             tail   <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          m_data <= tail;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            m_data <= push_data;
          end else begin
            m_data <= tail;
            tail   <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from the FIFO read port onto a valid/ready stream, then pulses done.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_left,
  input  logic                  fifo_empty,
  input  logic                  fifo_wen,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  localparam logic [LEN_WIDTH-1:0] CNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  rd_state_t            state, state_nxt;
  logic [LEN_WIDTH-1:0] issue_cnt;
  logic                 inflight;
  logic [1:0]           occ;
  logic [1:0]           used;
  logic                 xfer;

  assign xfer = m_valid && m_ready;
  // A word leaving this cycle frees its slot at the same edge the new read lands,
  // which is what allows one word per cycle with only two entries.
  assign used = occ + {1'b0, inflight} - {1'b0, xfer};

  assign fifo_ren = (state == READ) && (issue_cnt != '0) && !fifo_empty &&
                    !fifo_wen && (used < SKID_DEPTH);

  assign busy = (state == READ) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (burst_len == '0) ? DONE : READ;
      READ:  if (fifo_ren && issue_cnt == CNT_ONE) state_nxt = DRAIN;
      DRAIN: if (xfer && words_left == CNT_ONE) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      words_left <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_ren;
      if (state == IDLE && start) begin
        issue_cnt  <= burst_len;
        words_left <= burst_len;
      end else begin
        if (fifo_ren) issue_cnt  <= issue_cnt - CNT_ONE;
        if (xfer)     words_left <= words_left - CNT_ONE;
      end
    end
  end

  stream_skid2 #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .m_ready   (m_ready),
    .occ       (occ),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural FIFO read port.
module tb_fifo_burst_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  burst_len;
  logic        busy;
  logic        done;
  logic [9:0]  words_left;
  logic        fifo_empty;
  logic        fifo_wen;
  logic        fifo_ren;
  logic [15:0] fifo_dout;
  logic [15:0] wdata;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] fmem [0:63];
  int          wp = 0;
  int          rp = 0;

  int          rds = 0;
  int          xf  = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        saw9 = 1'b0;

  fifo_burst_reader #(
    .DATA_WIDTH(16),
    .LEN_WIDTH (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .words_left (words_left),
    .fifo_empty (fifo_empty),
    .fifo_wen   (fifo_wen),
    .fifo_ren   (fifo_ren),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Registered-output FIFO read port, reset together with the DUT.
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (!rst) begin
      wp        <= 0;
      rp        <= 0;
      fifo_dout <= '0;
    end else begin
      if (fifo_ren) begin
        fifo_dout <= fmem[rp % 64];
        rp        <= rp + 1;
      end
      if (fifo_wen) begin
        fmem[wp % 64] <= wdata;
        wp            <= wp + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      rds        = 0;
      xf         = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_ren) begin
        check("ren_gate", {30'd0, fifo_empty, fifo_wen}, 32'd0);
        check("outstanding", 32'((rds - xf + 1 - int'(m_valid && m_ready)) <= 2), 32'd1);
        rds++;
      end
      if (prev_stall) check("stall_hold", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else                   check("data", 32'(m_data), 32'(exp_q.pop_front()));
        xf++;
      end
      if (words_left == 10'd9) saw9 = 1'b1;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] v);
    fifo_wen = 1'b1;
    wdata    = v;
    exp_q.push_back(v);
    tick();
    fifo_wen = 1'b0;
  endtask

  // mode 0: m_ready=1; 1: m_ready pattern 1,0,0,1; 2: late FIFO writes;
  // 3: second start while busy. abort_at>0 asserts reset in that cycle and returns.
  task automatic run(input int len, input int mode, input int abort_at,
                     output int done_at, output int first_v, output int ren_cnt);
    logic [3:0] pat;
    int         k;
    pat     = 4'b1001;
    k       = 0;
    done_at = -1;
    first_v = -1;
    ren_cnt = 0;
    m_ready   = 1'b1;
    start     = 1'b1;
    burst_len = 10'(len);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      fifo_wen = 1'b0;
      start    = 1'b0;
      m_ready  = 1'b1;
      if (mode == 1) m_ready = pat[c % 4];
      if (mode == 2 && (c == 4 || c == 5 || c == 9)) begin
        fifo_wen = 1'b1;
        wdata    = 16'h2202 + 16'(k);
        exp_q.push_back(wdata);
        k++;
      end
      if (mode == 3 && c == 2) begin
        start     = 1'b1;
        burst_len = 10'd9;
      end
      if (c == abort_at) begin
        m_ready = 1'b0;
        rst     = 1'b0;
        return;
      end
      #1;
      if (fifo_ren) ren_cnt++;
      if (m_valid && first_v < 0) first_v = c;
      if (done) begin
        done_at = c;
        break;
      end
      tick();
    end
    fifo_wen = 1'b0;
    start    = 1'b0;
    if (done_at < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int d, f, r, x0;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    m_ready   = 1'b1;
    fifo_wen  = 1'b0;
    wdata     = '0;
    repeat (3) tick();
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_wleft",  32'(words_left), 32'd0);
    check("rst_ren",    32'(fifo_ren), 32'd0);
    check("rst_valid",  32'(m_valid), 32'd0);
    check("rst_data",   32'(m_data), 32'd0);
    rst = 1'b1;
    tick();

    // Basic burst of 8
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    x0 = xf;
    run(8, 0, 0, d, f, r);
    check("basic_first_valid", 32'(f), 32'd3);
    check("basic_ren_cycles",  32'(r), 32'd8);
    check("basic_done_at",     32'(d), 32'd11);
    check("basic_xfers",       32'(xf - x0), 32'd8);
    check("basic_busy_at_done", 32'(busy), 32'd0);
    check("basic_wleft",       32'(words_left), 32'd0);
    tick();
    check("basic_done_pulse",  32'(done), 32'd0);

    // Zero length
    run(0, 0, 0, d, f, r);
    check("zero_done_at",  32'(d), 32'd1);
    check("zero_ren",      32'(r), 32'd0);
    check("zero_valid",    32'(f), 32'hFFFF_FFFF);
    check("zero_busy",     32'(busy), 32'd0);
    tick();

    // Backpressure
    for (int i = 0; i < 6; i++) push_word(16'h1100 + 16'(i));
    x0 = xf;
    run(6, 1, 0, d, f, r);
    check("bp_xfers", 32'(xf - x0), 32'd6);
    check("bp_ren",   32'(r), 32'd6);
    check("bp_sb",    32'(exp_q.size()), 32'd0);
    check("bp_wleft", 32'(words_left), 32'd0);
    tick();

    // Empty FIFO and write contention
    push_word(16'h2200);
    push_word(16'h2201);
    x0 = xf;
    run(5, 2, 0, d, f, r);
    check("wen_xfers", 32'(xf - x0), 32'd5);
    check("wen_ren",   32'(r), 32'd5);
    check("wen_sb",    32'(exp_q.size()), 32'd0);
    check("wen_wleft", 32'(words_left), 32'd0);
    tick();

    // Start while busy
    for (int i = 0; i < 4; i++) push_word(16'h3300 + 16'(i));
    x0 = xf;
    run(4, 3, 0, d, f, r);
    check("sb2_xfers",   32'(xf - x0), 32'd4);
    check("sb2_ren",     32'(r), 32'd4);
    check("sb2_done_at", 32'(d), 32'd7);
    check("sb2_saw9",    32'(saw9), 32'd0);
    tick();
    check("sb2_idle",    32'(busy), 32'd0);

    // Reset mid-burst after three transfers
    for (int i = 0; i < 8; i++) push_word(16'h4400 + 16'(i));
    x0 = xf;
    run(8, 0, 6, d, f, r);
    check("mid_xfers_before", 32'(xf - x0), 32'd3);
    tick();
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_valid", 32'(m_valid), 32'd0);
    check("mid_wleft", 32'(words_left), 32'd0);
    check("mid_done",  32'(done), 32'd0);
    check("mid_data",  32'(m_data), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    tick();
    check("mid_done_after", 32'(done), 32'd0);
    push_word(16'h5501);
    push_word(16'h5502);
    x0 = xf;
    run(2, 0, 0, d, f, r);
    check("post_done_at", 32'(d), 32'd5);
    check("post_xfers",   32'(xf - x0), 32'd2);
    check("post_sb",      32'(exp_q.size()), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
